vram_write_scheduler: RTL and testbench
=======================================

// Module: vram_write_scheduler
// PURPOSE
// - Single-clock front end for the character buffer and font memory write ports; replaces direct SPI-clocked writes.
// - Oversamples SPI (sck/mosi/ss_n) in clk domain, assembles 32-bit command frames, decodes the address map.
// - Issues one-cycle write strobes to the char buffer or font memory; runs a hardware clear-screen fill sequence.
// PARAMETERS
// - CHAR_AW     13    char buffer address width
// - FONT_AW     12    font memory address width
// - DW          8     data width
// - SYNC_STAGES 2     synchroniser flops on sck, mosi, ss_n (>=2)
// - FILL_COUNT  4800  char cells written by FILL (80x60); must be <= 2**CHAR_AW
// PORTS
// - clk        in   1        system clock; all logic on posedge
// - rst_n      in   1        asynchronous active-low reset
// - sck        in   1        SPI clock (async, mode 0, sampled on rising edge)
// - mosi       in   1        SPI data, MSB first
// - ss_n       in   1        SPI select, active low
// - char_we    out  1        char buffer write strobe, 1 cycle per write
// - char_addr  out  CHAR_AW  char buffer write address
// - char_din   out  DW       char buffer write data
// - font_we    out  1        font memory write strobe, 1 cycle per write
// - font_addr  out  FONT_AW  font memory write address
// - font_din   out  DW       font memory write data
// - busy       out  1        high while FILL runs or pending slot occupied
// - frame_err  out  1        1-cycle pulse: partial frame, bad cmd/addr, or overrun
// - led        out  8        data byte of last accepted frame
// BEHAVIOUR
// - Reset: every output 0; state IDLE; bit counter 0; pending slot empty; shift register 0.
// - Frame: 32 bits MSB first = {cmd[31:24], data[23:16], addr[15:0]}.
// - sck rise is detected on the synchronised signal; mosi is shifted in only when synced ss_n=0.
// - A 6-bit counter counts bits. At 32 the frame is complete and the counter returns to 0.
// - Back-to-back frames within one ss_n low window are legal.
// - ss_n rising with counter != 0: discard the partial frame, pulse frame_err, clear counter.
// - ss_n high holds counter at 0.
// - Commands:
//   - 0x01 WRITE: addr[15:14]!=0 -> reject; addr[13]=0 -> char write at addr[12:0]; addr[13]=1 -> font write at addr[11:0].
//   - 0x02 FILL: write data to char cells 0..FILL_COUNT-1, one per clk; addr field ignored.
//   - Any other cmd: reject.
//   - Reject = frame_err pulse, no write, led unchanged.
// - FSM states IDLE, WRITE, FILL:
//   - IDLE: completed frame (or pending slot) -> decode. WRITE cmd -> WRITE; FILL cmd -> FILL with cnt=0.
//   - WRITE: assert the selected we for exactly 1 cycle with addr/din -> IDLE.
//   - FILL: char_we=1 each cycle, char_addr=cnt, cnt++; cycle with cnt=FILL_COUNT-1 is the last write -> IDLE.
// - Latency: the selected we asserts 2 clk after the cycle the 32nd bit is registered (decode, then strobe).
// - Exactly one of char_we/font_we is high in any cycle; both low otherwise; addr/din hold last value.
// - Frame completing while not IDLE is stored in a 1-entry pending slot; serviced on next IDLE, ahead of newer frames.
// - Frame completing while the slot is full: dropped, frame_err pulse (overrun). The stored frame is kept.
// - Frame completing in the last FILL cycle goes to the pending slot; it is not lost.
// - led updates when a frame is accepted (decoded valid), not when written.
// - busy = (state==FILL) | pending_valid.
// - rst_n low mid-FILL or mid-frame: immediate abort, all state to reset values; fill is not resumed.
// STRUCTURE
// - Shared package gpu_mem_pkg:
//   - command codes CMD_WRITE=8'h01, CMD_FILL=8'h02
//   - address-map constants: region select bit 13, reserved bits [15:14]
//   - frame field offsets
// - Sub-module spi_frame_rx: synchronisers, edge detect, shift register, bit counter.
//   - Outputs frame_valid pulse + frame[31:0] + partial_err pulse.
// - Top: decode, pending slot, FSM, fill counter, output registers.
// TESTING
// - Frame 0x01_5A_0010 -> one-cycle char_we, char_addr=0x0010, char_din=0x5A, font_we never high, led=0x5A.
// - Frame 0x01_3C_2FFF -> font_we, font_addr=0xFFF, din=0x3C; frame 0x01_11_4000 -> frame_err, no write.
// - Frame 0x02_20_0000 -> 4800 consecutive char_we cycles, addr 0..4799, din=0x20; busy high throughout.
// - FILL + second frame during fill: second write issued after addr 4799. Third frame during fill: frame_err, dropped.
// - ss_n raised after 17 bits -> frame_err pulse, no write. Next full frame 0x01_77_0001 -> written correctly.
// - rst_n asserted at fill addr 100 -> all outputs 0 at once. After release, idle with busy=0 and no further char_we.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: command codes, address-map constants and frame layout shared by the VRAM write path
package gpu_mem_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_FILL = 8'h02;
  localparam int REGION_BIT = 13;
  localparam int RSVD_HI = 15;
  localparam int RSVD_LO = 14;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL} state_t;
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [15:0] addr;
  } frame_t;
  function automatic logic frame_ok(input frame_t f);
    return f.cmd == CMD_FILL || (f.cmd == CMD_WRITE && f.addr[RSVD_HI:RSVD_LO] == 2'b00);
  endfunction
endpackage

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI mode-0 receiver assembling 32-bit MSB-first frames
// clk/rst_n: system clock, async active-low reset
// sck/mosi/ss_n: raw SPI inputs, synchronised here
// frame_valid: 1-cycle pulse when frame holds a complete frame
// frame: shift register contents
// partial_err: 1-cycle pulse when ss_n rises mid-frame
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        mosi,
  input  logic        ss_n,
  output logic        frame_valid,
  output logic [31:0] frame,
  output logic        partial_err
);
  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_ss_sync;
  logic r_sck_prev, r_ss_prev, r_valid, r_perr;
  logic [5:0] r_cnt;
  logic [31:0] r_shift;
  logic w_sck, w_mosi, w_ss_n, w_rise;
  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_n = r_ss_sync[SYNC_STAGES-1];
  assign w_rise = w_sck & ~r_sck_prev;
  assign frame_valid = r_valid;
  assign frame = r_shift;
  assign partial_err = r_perr;
  // ss_n synchroniser resets deselected so reset release is not seen as a select edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sck_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync <= '1;
      r_sck_prev <= 1'b0;
      r_ss_prev <= 1'b1;
      r_cnt <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
      r_sck_prev <= w_sck;
      r_ss_prev <= w_ss_n;
      r_valid <= 1'b0;
      r_perr <= 1'b0;
      if (w_ss_n) begin
        r_cnt <= '0;
        r_perr <= ~r_ss_prev & (r_cnt != 6'd0);
      end else if (w_rise) begin
        r_shift <= {r_shift[30:0], w_mosi};
        r_cnt <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
        r_valid <= r_cnt == 6'd31;
      end
    end
endmodule

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: SPI command front end issuing char/font write strobes and hardware clear-screen fill
// clk/rst_n: system clock, async active-low reset
// sck/mosi/ss_n: SPI slave inputs
// char_we/char_addr/char_din: char buffer write port
// font_we/font_addr/font_din: font memory write port
// busy: fill running or a frame waiting in the pending slot
// frame_err: 1-cycle pulse on partial frame, rejected frame or overrun
// led: data byte of the last accepted frame
module vram_write_scheduler
  import gpu_mem_pkg::*;
#(
  parameter int CHAR_AW = 13,
  parameter int FONT_AW = 12,
  parameter int DW = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILL_COUNT = 4800
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sck,
  input  logic               mosi,
  input  logic               ss_n,
  output logic               char_we,
  output logic [CHAR_AW-1:0] char_addr,
  output logic [DW-1:0]      char_din,
  output logic               font_we,
  output logic [FONT_AW-1:0] font_addr,
  output logic [DW-1:0]      font_din,
  output logic               busy,
  output logic               frame_err,
  output logic [7:0]         led
);
  localparam logic [CHAR_AW-1:0] LAST = CHAR_AW'(FILL_COUNT - 1);
  logic w_fv, w_perr;
  frame_t w_frame, r_sf, r_pf, w_dec;
  logic r_sv, r_pv;
  state_t r_state, w_state_n;
  logic [CHAR_AW-1:0] r_cnt, w_cnt_n, w_char_addr_n;
  logic [FONT_AW-1:0] w_font_addr_n;
  logic [DW-1:0] w_char_din_n, w_font_din_n;
  logic [7:0] w_led_n;
  logic w_char_we_n, w_font_we_n, w_rej;
  logic w_take_pend, w_take_stg, w_park, w_overrun;
  spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .sck(sck),
    .mosi(mosi),
    .ss_n(ss_n),
    .frame_valid(w_fv),
    .frame(w_frame),
    .partial_err(w_perr)
  );
  // the pending frame is older than the staged one, so it is decoded first
  assign w_take_pend = r_state == S_IDLE && r_pv;
  assign w_take_stg = r_state == S_IDLE && !r_pv && r_sv;
  assign w_dec = r_pv ? r_pf : r_sf;
  assign w_park = r_sv & ~w_take_stg;
  assign w_overrun = w_park & r_pv & ~w_take_pend;
  assign busy = (r_state == S_FILL) | r_pv;
  // outputs are computed one cycle ahead and registered, so the strobe lines up with WRITE/FILL
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    w_char_we_n = 1'b0;
    w_font_we_n = 1'b0;
    w_char_addr_n = char_addr;
    w_char_din_n = char_din;
    w_font_addr_n = font_addr;
    w_font_din_n = font_din;
    w_led_n = led;
    w_rej = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_take_pend || w_take_stg) begin
          if (!frame_ok(w_dec)) w_rej = 1'b1;
          else begin
            w_led_n = w_dec.data;
            if (w_dec.cmd == CMD_FILL) begin
              w_state_n = S_FILL;
              w_cnt_n = '0;
              w_char_we_n = 1'b1;
              w_char_addr_n = '0;
              w_char_din_n = w_dec.data;
            end else begin
              w_state_n = S_WRITE;
              if (w_dec.addr[REGION_BIT]) begin
                w_font_we_n = 1'b1;
                w_font_addr_n = w_dec.addr[FONT_AW-1:0];
                w_font_din_n = w_dec.data;
              end else begin
                w_char_we_n = 1'b1;
                w_char_addr_n = w_dec.addr[CHAR_AW-1:0];
                w_char_din_n = w_dec.data;
              end
            end
          end
        end
      S_WRITE: w_state_n = S_IDLE;
      S_FILL:
        if (r_cnt == LAST) w_state_n = S_IDLE;
        else begin
          w_cnt_n = r_cnt + 1'b1;
          w_char_we_n = 1'b1;
          w_char_addr_n = r_cnt + 1'b1;
        end
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_sv <= 1'b0;
      r_sf <= '0;
      r_pv <= 1'b0;
      r_pf <= '0;
      char_we <= 1'b0;
      char_addr <= '0;
      char_din <= '0;
      font_we <= 1'b0;
      font_addr <= '0;
      font_din <= '0;
      frame_err <= 1'b0;
      led <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_sv <= w_fv;
      r_sf <= w_frame;
      if (w_park && (!r_pv || w_take_pend)) begin
        r_pv <= 1'b1;
        r_pf <= r_sf;
      end else if (w_take_pend) r_pv <= 1'b0;
      char_we <= w_char_we_n;
      char_addr <= w_char_addr_n;
      char_din <= w_char_din_n;
      font_we <= w_font_we_n;
      font_addr <= w_font_addr_n;
      font_din <= w_font_din_n;
      frame_err <= w_perr | w_overrun | w_rej;
      led <= w_led_n;
    end
endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler: directed and randomized SPI frames checked against a transaction-level model
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end
module tb_vram_write_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic char_we, font_we, busy, frame_err;
  logic [12:0] char_addr;
  logic [11:0] font_addr;
  logic [7:0] char_din, font_din, led;
  typedef struct packed {
    logic font;
    logic [12:0] addr;
    logic [7:0] din;
    logic busy;
    logic [31:0] cyc;
  } wr_t;
  wr_t wlog[$];
  logic [21:0] exp_q[$];
  int cyc = 0, errs = 0, boths = 0, checks = 0, failures = 0;
  vram_write_scheduler dut (
    .clk(clk),
    .rst_n(rst_n),
    .sck(sck),
    .mosi(mosi),
    .ss_n(ss_n),
    .char_we(char_we),
    .char_addr(char_addr),
    .char_din(char_din),
    .font_we(font_we),
    .font_addr(font_addr),
    .font_din(font_din),
    .busy(busy),
    .frame_err(frame_err),
    .led(led)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (char_we) wlog.push_back({1'b0, char_addr, char_din, busy, 32'(cyc)});
      if (font_we) wlog.push_back({1'b1, 1'b0, font_addr, font_din, busy, 32'(cyc)});
      if (char_we && font_we) boths++;
      if (frame_err) errs++;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic send_bits(input logic [31:0] w, input int nb);
    for (int i = 31; i > 31 - nb; i--) begin
      mosi = w[i];
      tick(3);
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
    end
  endtask
  task automatic send_frame(input logic [31:0] w);
    ss_n = 1'b0;
    tick(3);
    send_bits(w, 32);
    tick(3);
    ss_n = 1'b1;
    tick(3);
  endtask
  initial begin
    int k, e0, bad, err_exp, found, nw;
    logic [31:0] fr[12];
    bit brk[12];
    logic [7:0] c, d, led_exp;
    logic [1:0] rs;
    logic [13:0] lo;
    logic [21:0] got;
    tick(3);
    `CHK("reset_outputs", {char_we, font_we, char_addr, char_din, font_addr, font_din, busy, frame_err, led}, 56'h0)
    rst_n = 1'b1;
    tick(5);
    `CHK("idle_busy", busy, 1'b0)
    // char write with exact strobe latency from the 32nd sck rise
    ss_n = 1'b0;
    tick(3);
    send_bits(32'h015A0010, 31);
    mosi = 1'b0;
    tick(3);
    sck = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (char_we) begin
        k = i;
        break;
      end
    end
    `CHK("char_latency", k, 5)
    `CHK("char_addr", char_addr, 13'h0010)
    `CHK("char_din", char_din, 8'h5A)
    `CHK("led_5a", led, 8'h5A)
    tick(1);
    `CHK("char_we_one_cycle", char_we, 1'b0)
    sck = 1'b0;
    tick(3);
    ss_n = 1'b1;
    tick(10);
    `CHK("char_only_one_write", wlog.size(), 1)
    `CHK("char_not_font", wlog[0].font, 1'b0)
    // font write
    wlog.delete();
    send_frame(32'h013C2FFF);
    tick(10);
    `CHK("font_count", wlog.size(), 1)
    `CHK("font_entry", {wlog[0].font, wlog[0].addr, wlog[0].din}, {1'b1, 13'h0FFF, 8'h3C})
    `CHK("led_3c", led, 8'h3C)
    // reserved address bits reject
    wlog.delete();
    e0 = errs;
    send_frame(32'h01114000);
    tick(10);
    `CHK("rsvd_err", errs - e0, 1)
    `CHK("rsvd_nowrite", wlog.size(), 0)
    `CHK("rsvd_led_kept", led, 8'h3C)
    // partial frame then a good one
    e0 = errs;
    ss_n = 1'b0;
    tick(3);
    send_bits(32'h01990002, 17);
    tick(3);
    ss_n = 1'b1;
    tick(10);
    `CHK("partial_err", errs - e0, 1)
    `CHK("partial_nowrite", wlog.size(), 0)
    send_frame(32'h01770001);
    tick(10);
    `CHK("after_partial", {wlog.size(), wlog[0].font, wlog[0].addr, wlog[0].din}, {32'd1, 1'b0, 13'h0001, 8'h77})
    // fill with a pending frame and an overrun frame
    wlog.delete();
    e0 = errs;
    send_frame(32'h02200000);
    send_frame(32'h01AB0123);
    send_frame(32'h01CD0456);
    tick(5000);
    `CHK("fill_total", wlog.size(), 4801)
    bad = 0;
    if (wlog.size() == 4801)
      for (int i = 0; i < 4800; i++)
        if (wlog[i].font || wlog[i].addr != 13'(i) || wlog[i].din != 8'h20 || !wlog[i].busy || wlog[i].cyc != wlog[0].cyc + 32'(i)) bad++;
    `CHK("fill_sequence", bad, 0)
    if (wlog.size() == 4801) `CHK("fill_pending_write", {wlog[4800].font, wlog[4800].addr, wlog[4800].din}, {1'b0, 13'h0123, 8'hAB})
    `CHK("fill_overrun_err", errs - e0, 1)
    `CHK("fill_led", led, 8'hAB)
    `CHK("fill_busy_end", busy, 1'b0)
    // reset in the middle of a fill
    send_frame(32'h02330000);
    found = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (char_we && char_addr == 13'd100) begin
        found = 1;
        break;
      end
    end
    `CHK("fill_reached_100", found, 1)
    rst_n = 1'b0;
    #1;
    `CHK("abort_outputs", {char_we, font_we, char_addr, char_din, font_addr, font_din, busy, frame_err, led}, 56'h0)
    tick(2);
    rst_n = 1'b1;
    wlog.delete();
    tick(50);
    `CHK("abort_no_resume", wlog.size(), 0)
    `CHK("abort_busy", busy, 1'b0)
    // random frames, some back-to-back in one select window
    led_exp = 8'h00;
    err_exp = 0;
    for (int n = 0; n < 12; n++) begin
      c = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(3, 255)) : 8'h01;
      d = 8'($urandom);
      rs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      lo = 14'($urandom);
      fr[n] = {c, d, rs, lo};
      brk[n] = $urandom_range(0, 1) == 1;
      if (c == 8'h01 && rs == 2'b00) begin
        exp_q.push_back(lo[13] ? {1'b1, 1'b0, lo[11:0], d} : {1'b0, lo[12:0], d});
        led_exp = d;
      end else err_exp++;
    end
    e0 = errs;
    ss_n = 1'b0;
    tick(3);
    for (int n = 0; n < 12; n++) begin
      send_bits(fr[n], 32);
      if (brk[n]) begin
        tick(3);
        ss_n = 1'b1;
        tick(4);
        ss_n = 1'b0;
        tick(3);
      end
    end
    tick(3);
    ss_n = 1'b1;
    tick(20);
    `CHK("rand_count", wlog.size(), exp_q.size())
    nw = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      got = {wlog[i].font, wlog[i].addr, wlog[i].din};
      if (got != exp_q[i]) bad++;
    end
    `CHK("rand_writes", bad, 0)
    `CHK("rand_errs", errs - e0, err_exp)
    `CHK("rand_led", led, led_exp)
    `CHK("never_both_we", boths, 0)
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
